alu_uart_ctrl: RTL

ALU_UART_CTRL -- requirements
Module: alu_uart_ctrl

---
 rtl/alu_uart_ctrl.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/alu_uart_ctrl.sv
// Sequencer between a UART and an ALU: collects operand A, operand B and an opcode byte,
// runs one ALU operation and hands the result byte to the transmitter.
module alu_uart_ctrl #(
   parameter int unsigned DATA_SIZE = 8,
   parameter int unsigned OP_SIZE   = 6,
   parameter int unsigned TIMEOUT   = 1000000
) (
   input  logic                 i_clk,
   input  logic                 i_reset,
   input  logic [DATA_SIZE-1:0] i_rx_data,
   input  logic                 i_rx_done,
   input  logic                 i_tx_done,
   input  logic [DATA_SIZE-1:0] i_alu_result,
   output logic [DATA_SIZE-1:0] o_alu_a,
   output logic [DATA_SIZE-1:0] o_alu_b,
   output logic [OP_SIZE-1:0]   o_alu_op,
   output logic [DATA_SIZE-1:0] o_tx_data,
   output logic                 o_tx_start,
   output logic                 o_busy,
   output logic                 o_op_err
);

   localparam int unsigned CntW = $clog2(TIMEOUT) + 1;
   localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT - 1);

   localparam logic [OP_SIZE-1:0] OpAdd = OP_SIZE'(6'b100000);
   localparam logic [OP_SIZE-1:0] OpSub = OP_SIZE'(6'b100010);
   localparam logic [OP_SIZE-1:0] OpAnd = OP_SIZE'(6'b100100);
   localparam logic [OP_SIZE-1:0] OpOr  = OP_SIZE'(6'b100101);
   localparam logic [OP_SIZE-1:0] OpXor = OP_SIZE'(6'b100110);
   localparam logic [OP_SIZE-1:0] OpSra = OP_SIZE'(6'b000011);
   localparam logic [OP_SIZE-1:0] OpSrl = OP_SIZE'(6'b000010);
   localparam logic [OP_SIZE-1:0] OpNor = OP_SIZE'(6'b100111);

   typedef enum logic [2:0] {
      StWaitA,
      StWaitB,
      StWaitOp,
      StExec,
      StSend,
      StWaitTx
   } state_e;

   state_e               state_q, state_d;
   logic [CntW-1:0]      cnt_q, cnt_d;
   logic [DATA_SIZE-1:0] a_q, a_d, b_q, b_d, tx_data_q, tx_data_d;
   logic [OP_SIZE-1:0]   op_q, op_d;
   logic                 tx_start_q, tx_start_d;
   logic                 op_err_q, op_err_d;
   logic                 timed_out;

   function automatic logic op_supported(input logic [OP_SIZE-1:0] op);
      logic ok;
      case (op)
         OpAdd, OpSub, OpAnd, OpOr, OpXor, OpSra, OpSrl, OpNor: ok = 1'b1;
         default:                                               ok = 1'b0;
      endcase
      return ok;
   endfunction

   assign timed_out = (cnt_q == CntMax);

   always_comb begin
      state_d    = state_q;
      a_d        = a_q;
      b_d        = b_q;
      op_d       = op_q;
      tx_data_d  = tx_data_q;
      tx_start_d = 1'b0;
      op_err_d   = 1'b0;
      cnt_d      = cnt_q;

      // A received byte always wins over a timeout in the same cycle.
      case (state_q)
         StWaitA: begin
            if (i_rx_done) begin
               a_d     = i_rx_data;
               state_d = StWaitB;
            end
         end
         StWaitB: begin
            if (i_rx_done) begin
               b_d     = i_rx_data;
               state_d = StWaitOp;
            end else if (timed_out) begin
               state_d = StWaitA;
            end
         end
         StWaitOp: begin
            if (i_rx_done) begin
               if (op_supported(i_rx_data[OP_SIZE-1:0])) begin
                  op_d    = i_rx_data[OP_SIZE-1:0];
                  state_d = StExec;
               end else begin
                  op_err_d = 1'b1;
                  state_d  = StWaitA;
               end
            end else if (timed_out) begin
               state_d = StWaitA;
            end
         end
         StExec: begin
            tx_data_d  = i_alu_result;
            tx_start_d = 1'b1;
            state_d    = StSend;
         end
         StSend: begin
            state_d = StWaitTx;
         end
         StWaitTx: begin
            if (i_tx_done) begin
               state_d = StWaitA;
            end
         end
         default: begin
            state_d = StWaitA;
         end
      endcase

      // Every accepted byte changes state, so a state change also covers byte acceptance.
      if (state_d != state_q) begin
         cnt_d = '0;
      end else if (state_q == StWaitB || state_q == StWaitOp) begin
         cnt_d = cnt_q + CntW'(1);
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q    <= StWaitA;
         cnt_q      <= '0;
         a_q        <= '0;
         b_q        <= '0;
         op_q       <= '0;
         tx_data_q  <= '0;
         tx_start_q <= 1'b0;
         op_err_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         a_q        <= a_d;
         b_q        <= b_d;
         op_q       <= op_d;
         tx_data_q  <= tx_data_d;
         tx_start_q <= tx_start_d;
         op_err_q   <= op_err_d;
      end
   end

   assign o_alu_a    = a_q;
   assign o_alu_b    = b_q;
   assign o_alu_op   = op_q;
   assign o_tx_data  = tx_data_q;
   assign o_tx_start = tx_start_q;
   assign o_op_err   = op_err_q;
   assign o_busy     = (state_q == StExec) || (state_q == StSend) || (state_q == StWaitTx);

endmodule
